hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
Pipeline sequencing controller for the 5-stage core: decides per cycle whether each stage advances, holds or is bubbled. It covers load-use hazards that the forwarding path cannot resolve, ID-stage taken-branch flushes, and the start/wait/done handshake of the multi-cycle MUL/DIV unit in EX. It also keeps a stall-cycle performance counter and a sticky timeout error.

Parameters:
MD_TIMEOUT, 64, maximum cycles in MD_WAIT before the timeout error is raised (range 2..255)
CNT_W, 32, width of the stall performance counter

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
RS1addrD_i  input  5  ID-stage rs1 address
RS2addrD_i  input  5  ID-stage rs2 address
RS1useD_i  input  1  ID instruction reads rs1
RS2useD_i  input  1  ID instruction reads rs2
RDaddrE_i  input  5  EX-stage rd address
MemReadE_i  input  1  EX instruction is a load
MulDivE_i  input  1  EX instruction is a MUL/DIV op
BranchTakenD_i  input  1  branch/jump resolved taken in ID
md_done_i  input  1  MUL/DIV unit result valid (level, sampled in MD_WAIT only)
md_start_o  output  1  one-cycle launch pulse to the MUL/DIV unit
PCWrite_o  output  1  PC register update enable
IFIDWrite_o  output  1  IF/ID register update enable
IFIDFlush_o  output  1  IF/ID loads a NOP
IDEXWrite_o  output  1  ID/EX register update enable
IDEXFlush_o  output  1  ID/EX loads a bubble (all control signals 0)
EXMEMBubble_o  output  1  EX/MEM loads a bubble
md_error_o  output  1  sticky MUL/DIV timeout flag
stall_cnt_o  output  CNT_W  count of cycles with PCWrite_o=0

Behaviour:
- Registered state: fsm (RUN, MD_WAIT), wait_cnt[7:0], stall_cnt_o, md_error_o. All other outputs are combinational from fsm and the inputs.
- Reset (async, rst_n_i=0): fsm=RUN, wait_cnt=0, stall_cnt_o=0, md_error_o=0. After reset, the combinational outputs are those of RUN with all inputs at 0: all write enables 1, all flush/bubble/start outputs 0.
- load_use = MemReadE_i & (RDaddrE_i!=0) & ((RS1useD_i & RS1addrD_i==RDaddrE_i) | (RS2useD_i & RS2addrD_i==RDaddrE_i)).
- RUN, priority from highest to lowest:
  1. MulDivE_i=1: md_start_o=1; PCWrite_o, IFIDWrite_o and IDEXWrite_o=0; EXMEMBubble_o=1; next state MD_WAIT with wait_cnt=0. load_use and the branch are ignored this cycle.
  2. load_use=1: PCWrite_o=0, IFIDWrite_o=0, IDEXFlush_o=1. A coincident BranchTakenD_i is suppressed (no IFIDFlush_o) and is re-evaluated on the next cycle.
  3. BranchTakenD_i=1: IFIDFlush_o=1; all enables 1.
  4. Otherwise all enables 1 and all flush/bubble/start outputs 0.
- MD_WAIT:
  - md_done_i=0: freeze as in RUN case 1 but with md_start_o=0. wait_cnt increments.
  - md_done_i=1: all enables 1, EXMEMBubble_o=0 (EX/MEM captures the result), next state RUN. load_use, BranchTakenD_i and MulDivE_i are ignored in this cycle.
  - Timeout: when wait_cnt reaches MD_TIMEOUT-1 with md_done_i=0, set md_error_o=1 and force next state RUN. The exit cycle uses the md_done_i=1 outputs, so the pipeline releases.
  - md_error_o clears only on reset.
- md_start_o is never asserted in two consecutive cycles. A MulDivE_i still set on the release cycle does not relaunch; that instruction leaves EX on the same edge.
- stall_cnt_o increments every cycle with PCWrite_o=0 and saturates at all-ones.
- Reset asserted in MD_WAIT returns immediately to RUN. No md_start_o pulse follows reset unless MulDivE_i=1.

Test Plan:
- Load-use on rs1: lw x5 in EX (MemReadE_i=1, RDaddrE_i=5), ID rs1=5 with RS1useD_i=1 -> exactly one cycle of PCWrite_o=0, IFIDWrite_o=0, IDEXFlush_o=1; stall_cnt_o goes 0→1.
- rd=x0 or unused source: RDaddrE_i=0 matching rs1, or rs2 match with RS2useD_i=0 -> no stall, all enables 1.
- Load-use and taken branch in the same cycle -> stall only, IFIDFlush_o=0; next cycle (no hazard, BranchTakenD_i held) -> IFIDFlush_o=1.
- MUL/DIV with md_done_i arriving 5 cycles after start -> md_start_o high for 1 cycle, freeze and EXMEMBubble_o for 5 cycles, release on the done cycle; stall_cnt_o=5; no second start pulse.
- md_done_i never arrives, MD_TIMEOUT=8 -> release after 8 frozen cycles with md_error_o=1 held until rst_n_i=0.
- rst_n_i pulsed low mid-MD_WAIT -> outputs return to RUN defaults immediately, stall_cnt_o=0, md_error_o=0.

Source files
------------

// File: rtl/hazard_stall_controller_if.sv
// Handshake bundle between the pipeline datapath and the hazard/stall controller.
// The master side drives hazard sources; the slave side (controller) returns stage controls.
interface hazard_stall_controller_if;
    logic [4:0] RS1addrD_i;
    logic [4:0] RS2addrD_i;
    logic       RS1useD_i;
    logic       RS2useD_i;
    logic [4:0] RDaddrE_i;
    logic       MemReadE_i;
    logic       MulDivE_i;
    logic       BranchTakenD_i;
    logic       md_done_i;
    logic       md_start_o;
    logic       PCWrite_o;
    logic       IFIDWrite_o;
    logic       IFIDFlush_o;
    logic       IDEXWrite_o;
    logic       IDEXFlush_o;
    logic       EXMEMBubble_o;

    modport master (
        output RS1addrD_i, RS2addrD_i, RS1useD_i, RS2useD_i, RDaddrE_i,
               MemReadE_i, MulDivE_i, BranchTakenD_i, md_done_i,
        input  md_start_o, PCWrite_o, IFIDWrite_o, IFIDFlush_o,
               IDEXWrite_o, IDEXFlush_o, EXMEMBubble_o
    );

    modport slave (
        input  RS1addrD_i, RS2addrD_i, RS1useD_i, RS2useD_i, RDaddrE_i,
               MemReadE_i, MulDivE_i, BranchTakenD_i, md_done_i,
        output md_start_o, PCWrite_o, IFIDWrite_o, IFIDFlush_o,
               IDEXWrite_o, IDEXFlush_o, EXMEMBubble_o
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// 5-stage pipeline sequencing: load-use stalls, ID branch flushes, MUL/DIV freeze with
// timeout, plus a saturating stall-cycle counter and a sticky timeout error.
module hazard_stall_controller #(
    parameter int unsigned MD_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    hazard_stall_controller_if.slave hz,
    output logic                     md_error_o,
    output logic [CNT_W-1:0]         stall_cnt_o
);

    typedef enum logic {RUN, MD_WAIT} state_e;

    localparam logic [7:0] WAIT_LAST = 8'(MD_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             md_error_q, md_error_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic load_use, timeout;
    logic md_start, pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_bubble;

    // x0 never creates a dependency; an unused source field may hold garbage.
    assign load_use = hz.MemReadE_i && (hz.RDaddrE_i != 5'd0) &&
                      ((hz.RS1useD_i && (hz.RS1addrD_i == hz.RDaddrE_i)) ||
                       (hz.RS2useD_i && (hz.RS2addrD_i == hz.RDaddrE_i)));

    assign timeout = (wait_cnt_q == WAIT_LAST) && !hz.md_done_i;

    always_comb begin
        md_start     = 1'b0;
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_we      = 1'b1;
        idex_flush   = 1'b0;
        exmem_bubble = 1'b0;
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        md_error_d   = md_error_q;
        case (state_q)
            RUN: begin
                if (hz.MulDivE_i) begin
                    md_start     = 1'b1;
                    pc_we        = 1'b0;
                    ifid_we      = 1'b0;
                    idex_we      = 1'b0;
                    exmem_bubble = 1'b1;
                    state_d      = MD_WAIT;
                    wait_cnt_d   = 8'd0;
                end else if (load_use) begin
                    // branch is held back; the stalled ID re-resolves it next cycle
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_flush = 1'b1;
                end else if (hz.BranchTakenD_i) begin
                    ifid_flush = 1'b1;
                end
            end
            MD_WAIT: begin
                // timeout exits through the same release path as a real done
                if (hz.md_done_i || timeout) begin
                    state_d = RUN;
                    if (timeout) md_error_d = 1'b1;
                end else begin
                    pc_we        = 1'b0;
                    ifid_we      = 1'b0;
                    idex_we      = 1'b0;
                    exmem_bubble = 1'b1;
                    wait_cnt_d   = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign stall_cnt_d = (!pc_we && (stall_cnt_q != {CNT_W{1'b1}})) ? stall_cnt_q + 1'b1
                                                                     : stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= RUN;
            wait_cnt_q  <= 8'd0;
            md_error_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            md_error_q  <= md_error_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.md_start_o    = md_start;
    assign hz.PCWrite_o     = pc_we;
    assign hz.IFIDWrite_o   = ifid_we;
    assign hz.IFIDFlush_o   = ifid_flush;
    assign hz.IDEXWrite_o   = idex_we;
    assign hz.IDEXFlush_o   = idex_flush;
    assign hz.EXMEMBubble_o = exmem_bubble;
    assign md_error_o       = md_error_q;
    assign stall_cnt_o      = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller (MD_TIMEOUT=8, 4-bit counter so saturation is reachable).
module tb_hazard_stall_controller;

    localparam int CNT_W = 4;

    // {md_start, PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, EXMEMBubble}
    localparam logic [6:0] O_RUN = 7'b0110100;
    localparam logic [6:0] O_LU  = 7'b0000110;
    localparam logic [6:0] O_BR  = 7'b0111100;
    localparam logic [6:0] O_MDS = 7'b1000001;
    localparam logic [6:0] O_FRZ = 7'b0000001;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             md_error;
    logic [CNT_W-1:0] stall_cnt;
    logic [6:0]       outs;
    int               total = 0;
    int               bad = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    hazard_stall_controller_if bus ();

    hazard_stall_controller #(.MD_TIMEOUT(8), .CNT_W(CNT_W)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .hz         (bus.slave),
        .md_error_o (md_error),
        .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    assign outs = {bus.md_start_o, bus.PCWrite_o, bus.IFIDWrite_o, bus.IFIDFlush_o,
                   bus.IDEXWrite_o, bus.IDEXFlush_o, bus.EXMEMBubble_o};

    task automatic clear_inputs();
        bus.RS1addrD_i = 5'd0; bus.RS2addrD_i = 5'd0;
        bus.RS1useD_i = 1'b0;  bus.RS2useD_i = 1'b0;
        bus.RDaddrE_i = 5'd0;  bus.MemReadE_i = 1'b0;
        bus.MulDivE_i = 1'b0;  bus.BranchTakenD_i = 1'b0;
        bus.md_done_i = 1'b0;
    endtask

    // inputs change 1 time unit after the edge; checks happen 1 unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #3;
        total++; if (outs !== O_RUN) begin bad++; $display("FAIL reset_outs got=%b exp=%b", outs, O_RUN); end
        total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
        total++; if (md_error !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", md_error); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_use_rs1();
        bus.MemReadE_i = 1'b1; bus.RDaddrE_i = 5'd5;
        bus.RS1addrD_i = 5'd5; bus.RS1useD_i = 1'b1;
        #1;
        total++; if (outs !== O_LU) begin bad++; $display("FAIL lu_rs1_outs got=%b exp=%b", outs, O_LU); end
        tick();
        exp_cnt++;
        clear_inputs();
        #1;
        total++; if (outs !== O_RUN) begin bad++; $display("FAIL lu_rs1_after got=%b exp=%b", outs, O_RUN); end
        total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL lu_rs1_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
        tick();
        total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL lu_rs1_cnt_hold got=%0d exp=%0d", stall_cnt, exp_cnt); end
    endtask

    task automatic test_no_stall();
        bus.MemReadE_i = 1'b1; bus.RDaddrE_i = 5'd0;
        bus.RS1addrD_i = 5'd0; bus.RS1useD_i = 1'b1;
        #1;
        total++; if (outs !== O_RUN) begin bad++; $display("FAIL rd_x0 got=%b exp=%b", outs, O_RUN); end
        tick();
        bus.RDaddrE_i = 5'd7; bus.RS1addrD_i = 5'd3;
        bus.RS2addrD_i = 5'd7; bus.RS2useD_i = 1'b0;
        #1;
        total++; if (outs !== O_RUN) begin bad++; $display("FAIL rs2_unused got=%b exp=%b", outs, O_RUN); end
        tick();
        bus.RS2useD_i = 1'b1;
        #1;
        total++; if (outs !== O_LU) begin bad++; $display("FAIL rs2_used got=%b exp=%b", outs, O_LU); end
        tick();
        exp_cnt++;
        bus.MemReadE_i = 1'b0;
        #1;
        total++; if (outs !== O_RUN) begin bad++; $display("FAIL not_load got=%b exp=%b", outs, O_RUN); end
        total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL no_stall_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
        tick();
        clear_inputs();
    endtask

    task automatic test_lu_branch();
        bus.MemReadE_i = 1'b1; bus.RDaddrE_i = 5'd9;
        bus.RS1addrD_i = 5'd9; bus.RS1useD_i = 1'b1;
        bus.BranchTakenD_i = 1'b1;
        #1;
        total++; if (outs !== O_LU) begin bad++; $display("FAIL lu_br_stall got=%b exp=%b", outs, O_LU); end
        tick();
        exp_cnt++;
        bus.MemReadE_i = 1'b0; bus.RDaddrE_i = 5'd0;
        #1;
        total++; if (outs !== O_BR) begin bad++; $display("FAIL lu_br_flush got=%b exp=%b", outs, O_BR); end
        tick();
        clear_inputs();
    endtask

    task automatic test_muldiv();
        bus.MulDivE_i = 1'b1;
        #1;
        total++; if (outs !== O_MDS) begin bad++; $display("FAIL md_start got=%b exp=%b", outs, O_MDS); end
        tick();
        for (int k = 1; k < 5; k++) begin
            #1;
            total++; if (outs !== O_FRZ) begin bad++; $display("FAIL md_freeze%0d got=%b exp=%b", k, outs, O_FRZ); end
            tick();
        end
        bus.md_done_i = 1'b1;
        #1;
        total++; if (outs !== O_RUN) begin bad++; $display("FAIL md_release got=%b exp=%b", outs, O_RUN); end
        tick();
        exp_cnt = exp_cnt + 4'd5;
        bus.md_done_i = 1'b0; bus.MulDivE_i = 1'b0;
        #1;
        total++; if (outs !== O_RUN) begin bad++; $display("FAIL md_after got=%b exp=%b", outs, O_RUN); end
        total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL md_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
        total++; if (md_error !== 1'b0) begin bad++; $display("FAIL md_err got=%b exp=0", md_error); end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        bus.MulDivE_i = 1'b1;
        tick();
        tick();
        #1;
        total++; if (outs !== O_FRZ) begin bad++; $display("FAIL rmw_frozen got=%b exp=%b", outs, O_FRZ); end
        rst_n = 1'b0; bus.MulDivE_i = 1'b0;
        #1;
        exp_cnt = '0;
        total++; if (outs !== O_RUN) begin bad++; $display("FAIL rmw_outs got=%b exp=%b", outs, O_RUN); end
        total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL rmw_cnt got=%0d exp=0", stall_cnt); end
        total++; if (md_error !== 1'b0) begin bad++; $display("FAIL rmw_err got=%b exp=0", md_error); end
        #1;
        rst_n = 1'b1;
        tick();
        total++; if (outs !== O_RUN) begin bad++; $display("FAIL rmw_nostart got=%b exp=%b", outs, O_RUN); end
    endtask

    task automatic test_timeout();
        bus.MulDivE_i = 1'b1;
        #1;
        total++; if (outs !== O_MDS) begin bad++; $display("FAIL to_start got=%b exp=%b", outs, O_MDS); end
        tick();
        for (int k = 0; k < 7; k++) begin
            #1;
            total++; if (outs !== O_FRZ) begin bad++; $display("FAIL to_freeze%0d got=%b exp=%b", k, outs, O_FRZ); end
            tick();
        end
        #1;
        total++; if (outs !== O_RUN) begin bad++; $display("FAIL to_release got=%b exp=%b", outs, O_RUN); end
        total++; if (md_error !== 1'b0) begin bad++; $display("FAIL to_err_early got=%b exp=0", md_error); end
        tick();
        exp_cnt = exp_cnt + 4'd8;
        bus.MulDivE_i = 1'b0;
        #1;
        total++; if (md_error !== 1'b1) begin bad++; $display("FAIL to_err_set got=%b exp=1", md_error); end
        total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL to_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
        total++; if (outs !== O_RUN) begin bad++; $display("FAIL to_after got=%b exp=%b", outs, O_RUN); end
        repeat (3) tick();
        total++; if (md_error !== 1'b1) begin bad++; $display("FAIL to_err_sticky got=%b exp=1", md_error); end
    endtask

    task automatic test_saturate();
        bus.MemReadE_i = 1'b1; bus.RDaddrE_i = 5'd4;
        bus.RS1addrD_i = 5'd4; bus.RS1useD_i = 1'b1;
        repeat (10) tick();
        clear_inputs();
        #1;
        total++; if (stall_cnt !== 4'hF) begin bad++; $display("FAIL sat_cnt got=%0d exp=15", stall_cnt); end
        total++; if (md_error !== 1'b1) begin bad++; $display("FAIL sat_err got=%b exp=1", md_error); end
        rst_n = 1'b0;
        #1;
        total++; if (md_error !== 1'b0) begin bad++; $display("FAIL final_err got=%b exp=0", md_error); end
        total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL final_cnt got=%0d exp=0", stall_cnt); end
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use_rs1();
        test_no_stall();
        test_lu_branch();
        test_muldiv();
        test_reset_mid_wait();
        test_timeout();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
